// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_pkg
// Purpose  : Shared UART types and divisor math for the transmitter/receiver.
// Revision : 1.0 - initial release
// ============================================================================
package uart_pkg;

    localparam int unsigned UART_DATA_BITS = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_tx_state_t;

    // Truncating divide so both ends of the link agree on the bit period.
    function automatic int unsigned clks_per_bit(input int unsigned clk_hz,
                                                 input int unsigned baud);
        return clk_hz / baud;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_baud_gen.sv
`default_nettype none
// ============================================================================
// Module   : uart_baud_gen
// Purpose  : Reloadable bit-period down-counter; tick marks the terminal count.
// Revision : 1.0 - initial release
// ============================================================================
module uart_baud_gen #(
    parameter int unsigned CLKS_PER_BIT = 10
) (
    input  logic clk,
    input  logic rst_n,
    input  logic restart,
    output logic tick,
    output logic pre_tick
);

    localparam int unsigned c_cnt_w = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [c_cnt_w-1:0] c_reload = c_cnt_w'(CLKS_PER_BIT - 1);
    localparam logic [c_cnt_w-1:0] c_one    = c_cnt_w'(1);

    logic [c_cnt_w-1:0] r_count;

    // Reloading at terminal count keeps every bit exactly CLKS_PER_BIT long.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (restart || (r_count == '0)) begin
            r_count <= c_reload;
        end else begin
            r_count <= r_count - c_one;
        end
    end

    assign tick     = (r_count == '0);
    // Terminal count arrives next cycle; lets the parent register its strobes.
    assign pre_tick = (r_count == c_one) && !restart;

endmodule
`default_nettype wire

// File: rtl/uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx
// Purpose  : 8-bit LSB-first UART transmitter with valid/ready byte intake.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned CLK_HZ    = 50_000_000,
    parameter int unsigned BAUD      = 9600,
    parameter int unsigned STOP_BITS = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] data_i,
    input  logic       valid_i,
    output logic       ready_o,
    output logic       tx_o,
    output logic       busy_o,
    output logic       done_o
);

    localparam int unsigned c_clks_per_bit = clks_per_bit(CLK_HZ, BAUD);
    localparam logic [2:0]  c_last_data_idx = 3'(UART_DATA_BITS - 1);
    localparam logic [2:0]  c_last_stop_idx = 3'(STOP_BITS - 1);

    generate
        if (c_clks_per_bit < 2) begin : g_bad_divisor
            $error("uart_tx: CLK_HZ/BAUD must be at least 2");
        end
        if ((STOP_BITS != 1) && (STOP_BITS != 2)) begin : g_bad_stop_bits
            $error("uart_tx: STOP_BITS must be 1 or 2");
        end
    endgenerate

    uart_tx_state_t            r_state;
    uart_tx_state_t            w_state_next;
    logic [UART_DATA_BITS-1:0] r_shift;
    logic [UART_DATA_BITS-1:0] w_shift_next;
    logic [2:0]                r_bit_idx;
    logic [2:0]                w_bit_idx_next;
    logic                      w_restart;
    logic                      w_tick;
    logic                      w_pre_tick;
    logic                      r_tx;
    logic                      r_busy;
    logic                      r_ready;
    logic                      r_done;
    logic                      w_tx_next;
    logic                      w_busy_next;
    logic                      w_done_next;

    uart_baud_gen #(
        .CLKS_PER_BIT (c_clks_per_bit)
    ) u_baud_gen (
        .clk      (clk),
        .rst_n    (rst_n),
        .restart  (w_restart),
        .tick     (w_tick),
        .pre_tick (w_pre_tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_shift   <= '0;
            r_bit_idx <= '0;
            r_tx      <= 1'b1;
            r_busy    <= 1'b0;
            r_ready   <= 1'b1;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_shift   <= w_shift_next;
            r_bit_idx <= w_bit_idx_next;
            r_tx      <= w_tx_next;
            r_busy    <= w_busy_next;
            r_ready   <= !w_busy_next;
            r_done    <= w_done_next;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_shift_next   = r_shift;
        w_bit_idx_next = r_bit_idx;
        w_restart      = 1'b0;

        case (r_state)
            IDLE: begin
                if (valid_i && r_ready) begin
                    w_shift_next   = data_i;
                    w_bit_idx_next = '0;
                    w_restart      = 1'b1;
                    w_state_next   = START;
                end
            end
            START: begin
                if (w_tick) begin
                    w_state_next = DATA;
                end
            end
            DATA: begin
                if (w_tick) begin
                    if (r_bit_idx == c_last_data_idx) begin
                        w_state_next   = STOP;
                        w_bit_idx_next = '0;
                    end else begin
                        w_shift_next   = r_shift >> 1;
                        w_bit_idx_next = r_bit_idx + 3'd1;
                    end
                end
            end
            STOP: begin
                // The bit index is reused to count stop bits.
                if (w_tick) begin
                    if (r_bit_idx == c_last_stop_idx) begin
                        w_state_next   = IDLE;
                        w_bit_idx_next = '0;
                    end else begin
                        w_bit_idx_next = r_bit_idx + 3'd1;
                    end
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase

        case (w_state_next)
            START:   w_tx_next = 1'b0;
            DATA:    w_tx_next = w_shift_next[0];
            default: w_tx_next = 1'b1;
        endcase

        w_busy_next = (w_state_next != IDLE);
        w_done_next = (r_state == STOP) && (r_bit_idx == c_last_stop_idx) && w_pre_tick;
    end

    assign tx_o    = r_tx;
    assign busy_o  = r_busy;
    assign ready_o = r_ready;
    assign done_o  = r_done;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx
// Purpose  : Self-checking bench for uart_tx against a frame-level line model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx;

    localparam int C    = 10;          // 1000 Hz / 100 baud
    localparam int L    = 10 * C;      // frame length with one stop bit
    localparam int C2   = 5208;        // default divisor
    localparam int L2   = 11 * C2;     // frame length with two stop bits

    logic       clk     = 1'b0;
    logic       rst_n   = 1'b0;
    logic [7:0] data_i  = 8'h00;
    logic       valid_i = 1'b0;
    logic       ready_o, tx_o, busy_o, done_o;
    logic [7:0] data2   = 8'h00;
    logic       valid2  = 1'b0;
    logic       ready2, tx2, busy2, done2;

    int cyc    = 0;
    int n_cmp  = 0;
    int n_fail = 0;

    uart_tx #(.CLK_HZ(1000), .BAUD(100), .STOP_BITS(1)) dut (
        .clk(clk), .rst_n(rst_n), .data_i(data_i), .valid_i(valid_i),
        .ready_o(ready_o), .tx_o(tx_o), .busy_o(busy_o), .done_o(done_o)
    );

    uart_tx #(.STOP_BITS(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .data_i(data2), .valid_i(valid2),
        .ready_o(ready2), .tx_o(tx2), .busy_o(busy2), .done_o(done2)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Line level on cycle k (1-based from the handshake) of a frame carrying b.
    function automatic logic exp_line(input int k, input logic [7:0] b);
        if (k <= C)     return 1'b0;
        if (k <= 9 * C) return b[(k - 1) / C - 1];
        return 1'b1;
    endfunction

    // Frame-level model: idle, or cycle m_k of a frame carrying m_byte.
    bit         m_active = 1'b0;
    int         m_k      = 0;
    logic [7:0] m_byte   = 8'h00;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_active = 1'b0;
        end else if (!m_active) begin
            if (valid_i) begin
                m_active = 1'b1;
                m_k      = 1;
                m_byte   = data_i;
            end
        end else if (m_k == L) begin
            m_active = 1'b0;
        end else begin
            m_k++;
        end
        #1;
        chk("tx_o",    tx_o,    m_active ? exp_line(m_k, m_byte) : 1'b1);
        chk("busy_o",  busy_o,  m_active);
        chk("ready_o", ready_o, !m_active);
        chk("done_o",  done_o,  m_active && (m_k == L));
    end

    task automatic wait_ready(input string name);
        int i;
        i = 0;
        while (!ready_o && i < 300) begin
            @(negedge clk);
            i++;
        end
        chk(name, ready_o, 1'b1);
    endtask

    // Returns one posedge+1 after handshake edge N, i.e. in cycle N+1.
    task automatic send(input logic [7:0] b, output int e);
        @(negedge clk);
        valid_i = 1'b1;
        data_i  = b;
        wait_ready("send_ready");
        @(posedge clk);
        #1;
        e       = cyc;
        valid_i = 1'b0;
    endtask

    // Reference receiver over cycles 1..101 of a frame; ends in cycle 101.
    task automatic capture(output logic [7:0] b, output int done_at, output int n_done,
                           output logic rdy101, output logic start_lvl);
        b = 8'h00; done_at = 0; n_done = 0; rdy101 = 1'b0; start_lvl = 1'b1;
        for (int k = 1; k <= 101; k++) begin
            if (k == C / 2) start_lvl = tx_o;
            if (k > C && k <= 9 * C && ((k - C) % C) == C / 2) b[(k - C) / C] = tx_o;
            if (done_o) begin
                n_done++;
                done_at = k;
            end
            if (k == 101) rdy101 = ready_o;
            else begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    initial begin
        logic [7:0] b, b2;
        int         e, e2, da, nd, run, stop_run;
        logic       rdy, st, sb;

        // Reset values and quiet line
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_tx",    tx_o,    1'b1);
        chk("rst_ready", ready_o, 1'b1);
        chk("rst_busy",  busy_o,  1'b0);
        chk("rst_done",  done_o,  1'b0);
        repeat (50) @(negedge clk);

        // Single byte 0x35: bits 1,0,1,0,1,1,0,0
        send(8'h35, e);
        capture(b, da, nd, rdy, st);
        chk("b35_start", st, 1'b0);
        chk("b35_byte",  b, 8'b0011_0101);
        chk("b35_done_cycle", da, 100);
        chk("b35_done_count", nd, 1);
        chk("b35_ready101",   rdy, 1'b1);

        // valid_i while busy is ignored
        send(8'hA5, e);
        fork
            capture(b, da, nd, rdy, st);
            begin
                repeat (29) @(negedge clk);
                valid_i = 1'b1;
                data_i  = 8'hFF;
                @(negedge clk);
                valid_i = 1'b0;
            end
        join
        chk("busy_ign_byte", b, 8'hA5);
        chk("busy_ign_done", nd, 1);
        repeat (20) @(negedge clk);
        chk("busy_ign_no_second", busy_o, 1'b0);

        // Back-to-back with valid_i held high
        @(negedge clk);
        valid_i = 1'b1;
        data_i  = 8'h00;
        wait_ready("b2b_ready");
        @(posedge clk);
        #1;
        e      = cyc;
        data_i = 8'hFF;
        capture(b, da, nd, rdy, st);
        chk("b2b_first_byte", b, 8'h00);
        chk("b2b_idle_ready", rdy, 1'b1);
        @(posedge clk);
        #1;
        e2      = cyc;
        valid_i = 1'b0;
        chk("b2b_gap", e2 - e, 101);
        capture(b, da, nd, rdy, st);
        chk("b2b_second_byte", b, 8'hFF);
        chk("b2b_second_done", da, 100);

        // Reset during data bit 3 of 0x0F
        send(8'h0F, e);
        repeat (44) @(negedge clk);
        chk("midrst_busy_before", busy_o, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("midrst_tx",    tx_o,    1'b1);
        chk("midrst_busy",  busy_o,  1'b0);
        chk("midrst_ready", ready_o, 1'b1);
        chk("midrst_done",  done_o,  1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        send(8'h5A, e);
        capture(b, da, nd, rdy, st);
        chk("postrst_byte", b, 8'h5A);
        chk("postrst_done", nd, 1);

        // Random valid/data traffic, checked cycle by cycle by the model
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            valid_i = ($urandom_range(0, 9) < 3);
            data_i  = 8'($urandom);
        end
        valid_i = 1'b0;
        repeat (110) @(negedge clk);

        // Two stop bits at the default divisor
        @(negedge clk);
        valid2 = 1'b1;
        data2  = 8'h55;
        chk("sb2_ready", ready2, 1'b1);
        @(posedge clk);
        #1;
        valid2 = 1'b0;
        data2  = 8'hFF;
        b2 = 8'h00; sb = 1'b1; run = 0; stop_run = 0; da = 0;
        for (int k = 1; k <= L2 + 100; k++) begin
            if (k == C2 / 2) sb = tx2;
            if (k > C2 && k <= 9 * C2 && ((k - C2) % C2) == C2 / 2) b2[(k - C2) / C2] = tx2;
            run = tx2 ? run + 1 : 0;
            if (done2) begin
                da       = k;
                stop_run = run;
                break;
            end
            @(posedge clk);
            #1;
        end
        chk("sb2_start",     sb, 1'b0);
        chk("sb2_byte",      b2, 8'h55);
        chk("sb2_frame_len", da, 57288);
        chk("sb2_stop_len",  stop_run, 10416);
        @(posedge clk);
        #1;
        chk("sb2_idle_ready", ready2, 1'b1);
        chk("sb2_idle_tx",    tx2,    1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
